// File: rtl/full_adder.sv
// full_adder: 1-bit full adder built from two half-adders with an optional registered output.
module full_adder #(
  parameter bit OUT_REG = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout,
  output logic Sum_q,
  output logic Cout_q
);
  logic p, g1, g2, sum_d, cout_d;
  always_comb begin
    p      = A ^ B;
    g1     = A & B;
    sum_d  = p ^ Cin;
    g2     = p & Cin;
    cout_d = g1 | g2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum_q  <= 1'b0;
      Cout_q <= 1'b0;
    end else begin
      Sum_q  <= sum_d;
      Cout_q <= cout_d;
    end
  end
  // OUT_REG selects between zero-latency ripple use and pipelined use
  assign Sum  = OUT_REG ? Sum_q  : sum_d;
  assign Cout = OUT_REG ? Cout_q : cout_d;
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: randomized and directed checks of full_adder against an arithmetic reference.
module tb_full_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, ci = 1'b0;
  logic s0, c0, s0_q, c0_q;
  logic s1, c1, s1_q, c1_q;
  logic [3:0] ra = '0, rb = '0;
  logic rci = 1'b0;
  logic [4:0] rcy;
  logic [3:0] rs, rs_q, rc_q;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  full_adder #(.OUT_REG(1'b0)) u0 (.clk(clk), .rst(rst), .A(a), .B(b), .Cin(ci),
    .Sum(s0), .Cout(c0), .Sum_q(s0_q), .Cout_q(c0_q));
  full_adder #(.OUT_REG(1'b1)) u1 (.clk(clk), .rst(rst), .A(a), .B(b), .Cin(ci),
    .Sum(s1), .Cout(c1), .Sum_q(s1_q), .Cout_q(c1_q));

  assign rcy[0] = rci;
  for (genvar g = 0; g < 4; g++) begin : g_rip
    full_adder #(.OUT_REG(1'b0)) u_r (.clk(clk), .rst(rst), .A(ra[g]), .B(rb[g]), .Cin(rcy[g]),
      .Sum(rs[g]), .Cout(rcy[g+1]), .Sum_q(rs_q[g]), .Cout_q(rc_q[g]));
  end

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] add3(input logic x, input logic y, input logic z);
    return 2'(int'(x) + int'(y) + int'(z));
  endfunction

  initial begin
    logic [1:0] exp_q;
    logic [2:0] v;
    // combinational truth table, clock irrelevant
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a, b, ci} = v;
      #5;
      chk("tt_comb", {3'b0, c0, s0}, {3'b0, add3(v[2], v[1], v[0])});
    end
    // reset with all ones applied
    @(negedge clk);
    rst = 1'b1; {a, b, ci} = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", {3'b0, c0_q, s0_q}, 5'd0);
    chk("rst_comb", {3'b0, c0, s0}, 5'd3);
    chk("rst_oreg", {3'b0, c1, s1}, 5'd0);
    // one-cycle latency
    @(negedge clk);
    rst = 1'b0; {a, b, ci} = 3'b101;
    @(posedge clk); #1;
    chk("lat_n", {3'b0, c0_q, s0_q}, 5'd2);
    @(negedge clk);
    {a, b, ci} = 3'b000;
    #1;
    chk("lat_hold", {3'b0, c0_q, s0_q}, 5'd2);
    chk("lat_comb", {3'b0, c0, s0}, 5'd0);
    @(posedge clk); #1;
    chk("lat_n1", {3'b0, c0_q, s0_q}, 5'd0);
    // random stream with a single-edge reset in the middle
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      a = 1'($urandom); b = 1'($urandom); ci = 1'($urandom);
      rst = (k == 20);
      exp_q = rst ? 2'd0 : add3(a, b, ci);
      #1;
      chk("rnd_comb", {3'b0, c0, s0}, {3'b0, add3(a, b, ci)});
      @(posedge clk); #1;
      chk("rnd_q", {3'b0, c0_q, s0_q}, {3'b0, exp_q});
      chk("rnd_oreg", {3'b0, c1, s1}, {3'b0, exp_q});
    end
    rst = 1'b0;
    // OUT_REG=1 exhaustive, one vector per cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v = 3'(i);
      {a, b, ci} = v;
      @(posedge clk); #1;
      chk("oreg_tt", {3'b0, c1, s1}, {3'b0, add3(v[2], v[1], v[0])});
    end
    // 4-bit ripple chain
    @(negedge clk);
    ra = 4'hF; rb = 4'h1; rci = 1'b0;
    #1;
    chk("rip_f1", {rcy[4], rs}, 5'h10);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ra = 4'($urandom); rb = 4'($urandom); rci = 1'($urandom);
      #1;
      chk("rip_rnd", {rcy[4], rs}, 5'(int'(ra) + int'(rb) + int'(rci)));
      @(posedge clk); #1;
      chk("rip_q", {1'b0, rs_q}, {1'b0, 4'(int'(ra) + int'(rb) + int'(rci))});
      chk("rip_cq", {4'b0, rc_q[3]}, {4'b0, 1'(((int'(ra) + int'(rb) + int'(rci)) >> 4))});
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- 1-bit full adder for the arithmetic unit ("Rechenwerk"): adds A + B + Cin and yields Sum and Cout.
- Primary outputs Sum/Cout are purely combinational so they can be cascaded into ripple-carry chains.
- Registered copies (Sum_q/Cout_q) are provided for pipelined use and are clocked by the single system clock with synchronous reset.

Parameters:
- OUT_REG, 0, when 1 the primary outputs Sum/Cout are taken from the registered copies (1-cycle latency); when 0 they are combinational (zero latency).

Ports:
- clk   input   1  system clock, rising edge active
- rst   input   1  reset, synchronous, active-high
- A     input   1  addend bit
- B     input   1  addend bit
- Cin   input   1  carry in
- Sum   output  1  sum bit = A ^ B ^ Cin (combinational when OUT_REG=0)
- Cout  output  1  carry out = (A&B) | (Cin&(A^B)) (combinational when OUT_REG=0)
- Sum_q   output  1  registered Sum
- Cout_q  output  1  registered Cout

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-high.
- Arithmetic: {Cout, Sum} = A + B + Cin as a 2-bit result, range 0..3.
- Structure: two half-adders plus an OR gate.
  - Half-adder 1: p = A^B, g1 = A&B.
  - Half-adder 2: Sum = p^Cin, g2 = p&Cin.
  - Cout = g1 | g2.
- Combinational path (OUT_REG=0):
  - Sum/Cout settle within the same delta/propagation window as any input change.
  - They are independent of clk and rst; rst does not force them.
- Registered path:
  - On each rising clk edge: if rst=1, Sum_q<=0 and Cout_q<=0; otherwise Sum_q<=comb Sum, Cout_q<=comb Cout.
  - Latency is exactly 1 cycle.
- Reset values: Sum_q=0, Cout_q=0. Sum/Cout also read 0 after reset when OUT_REG=1. With OUT_REG=0, Sum/Cout have no reset value and follow the inputs.
- Reset mid-operation:
  - A synchronous rst asserted at any edge clears the registers at that edge only.
  - The first edge with rst=0 captures the current inputs.
- Simultaneous input changes (e.g. A and Cin toggling together): outputs reflect the final input vector; no state is held beyond the registers.
- X/Z inputs are not supported; behaviour is don't-care.
- No handshake; inputs are sampled every cycle.

Test Plan:
- Exhaustive truth table, OUT_REG=0, no clock required: apply all 8 (A,B,Cin) vectors at 5 ns intervals -> (Sum,Cout) = 000->(0,0), 010->(1,0), 100->(1,0), 110->(0,1), 001->(1,0), 011->(0,1), 101->(0,1), 111->(1,1).
- Reset: hold rst=1 for 2 edges with A=B=Cin=1 -> Sum_q=0, Cout_q=0; comb Sum=1, Cout=1.
- Latency: release rst, apply A=1,B=0,Cin=1 before edge N -> Sum_q=0, Cout_q=1 after edge N; change inputs to 0,0,0 -> registered outputs update only at edge N+1.
- Mid-stream reset: run random vectors, assert rst for one edge -> Sum_q/Cout_q=0 at that edge only, resume tracking at the next edge.
- OUT_REG=1 exhaustive: all 8 vectors, one per cycle -> Sum/Cout equal the expected truth-table values one cycle later.
- Ripple check: chain 4 instances (OUT_REG=0), 0xF + 0x1 with Cin=0 -> sum 0x0, final Cout=1.
